// File: rtl/xor_link_host.sv
// Host-side endpoint of the XOR cipher serial link: shifts key and message out
// with load strobes, then collects the framed ciphertext back into a word.
module xor_link_host #(
  parameter int KEY_SIZE = 32,
  parameter int MSG_SIZE = 512,
  parameter int TIMEOUT  = 4096
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic [KEY_SIZE-1:0] iKey,
  input  logic [MSG_SIZE-1:0] iMessage,
  input  logic                iSerial_out,
  input  logic                iSerial_start,
  input  logic                iSerial_end,
  output logic                oSerial_in,
  output logic                oLoad_key,
  output logic                oLoad_msg,
  output logic                oBusy,
  output logic [MSG_SIZE-1:0] oCiphertext,
  output logic                oDone,
  output logic                oError
);

  // The bit counter is shared by key, message and receive phases (KEY_SIZE <= MSG_SIZE).
  localparam int CW = $clog2(MSG_SIZE) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [CW-1:0] KEY_LAST = CW'(KEY_SIZE - 1);
  localparam logic [CW-1:0] MSG_LAST = CW'(MSG_SIZE - 1);
  localparam logic [CW-1:0] MSG_FULL = CW'(MSG_SIZE);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic          ONE_BIT_FRAME = (MSG_SIZE == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_KEY,
    S_GAP,
    S_SEND_MSG,
    S_WAIT_RX,
    S_RECV,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [KEY_SIZE-1:0] r_key;
  logic [MSG_SIZE-1:0] r_msg;
  logic [MSG_SIZE-1:0] r_cipher;
  logic [CW-1:0]       r_bitCnt;
  logic [TW-1:0]       r_tmoCnt;
  logic                r_serialIn;
  logic                r_loadKey;
  logic                r_loadMsg;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic [CW-1:0]       w_rxNext;

  assign w_rxNext = r_bitCnt + CW'(1);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_msg      <= '0;
      r_cipher   <= '0;
      r_bitCnt   <= '0;
      r_tmoCnt   <= '0;
      r_serialIn <= 1'b0;
      r_loadKey  <= 1'b0;
      r_loadMsg  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_serialIn <= 1'b0;
          r_loadKey  <= 1'b0;
          r_loadMsg  <= 1'b0;
          if (iStart) begin
            r_key    <= iKey;
            r_msg    <= iMessage;
            r_cipher <= '0;
            r_bitCnt <= '0;
            r_error  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_SEND_KEY;
          end
        end

        S_SEND_KEY: begin
          r_loadKey  <= 1'b1;
          r_serialIn <= r_key[KEY_SIZE-1];
          r_key      <= r_key << 1;
          if (r_bitCnt == KEY_LAST) begin
            r_bitCnt <= '0;
            r_state  <= S_GAP;
          end else begin
            r_bitCnt <= r_bitCnt + CW'(1);
          end
        end

        S_GAP: begin
          r_loadKey  <= 1'b0;
          r_serialIn <= 1'b0;
          r_state    <= S_SEND_MSG;
        end

        S_SEND_MSG: begin
          r_loadMsg  <= 1'b1;
          r_serialIn <= r_msg[MSG_SIZE-1];
          r_msg      <= r_msg << 1;
          if (r_bitCnt == MSG_LAST) begin
            r_bitCnt <= '0;
            r_tmoCnt <= '0;
            r_state  <= S_WAIT_RX;
          end else begin
            r_bitCnt <= r_bitCnt + CW'(1);
          end
        end

        // A start bit may also carry the end flag; that frame is judged right here.
        S_WAIT_RX: begin
          r_loadMsg  <= 1'b0;
          r_serialIn <= 1'b0;
          if (iSerial_start) begin
            r_cipher <= {r_cipher[MSG_SIZE-2:0], iSerial_out};
            r_bitCnt <= CW'(1);
            if (iSerial_end) begin
              r_error <= !ONE_BIT_FRAME;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RECV;
            end
          end else if (r_tmoCnt == TMO_LAST) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmoCnt <= r_tmoCnt + TW'(1);
          end
        end

        // Ends on the end flag or when the word is full; only both together is clean.
        S_RECV: begin
          r_cipher <= {r_cipher[MSG_SIZE-2:0], iSerial_out};
          r_bitCnt <= w_rxNext;
          if (iSerial_end || (w_rxNext == MSG_FULL)) begin
            r_error <= !(iSerial_end && (w_rxNext == MSG_FULL));
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oSerial_in  = r_serialIn;
  assign oLoad_key   = r_loadKey;
  assign oLoad_msg   = r_loadMsg;
  assign oBusy       = r_busy;
  assign oCiphertext = r_cipher;
  assign oDone       = r_done;
  assign oError      = r_error;

endmodule

// File: tb/tb_xor_link_host.sv
// Directed bench for xor_link_host: framing, loopback, short frame, overrun,
// timeout and mid-transaction reset, with hand-computed expectations.
module tb_xor_link_host;

  localparam int KS = 32;
  localparam int MS = 512;
  localparam int TO = 4096;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic [KS-1:0] iKey;
  logic [MS-1:0] iMessage;
  logic          iSerial_out;
  logic          iSerial_start;
  logic          iSerial_end;
  logic          oSerial_in;
  logic          oLoad_key;
  logic          oLoad_msg;
  logic          oBusy;
  logic [MS-1:0] oCiphertext;
  logic          oDone;
  logic          oError;

  int errors = 0;
  int checks = 0;

  localparam logic [KS-1:0] KEY = 32'hDEADBEEF;
  localparam logic [MS-1:0] MSG = {16{32'h01234567}};
  // 0x01234567 ^ 0xDEADBEEF worked out by hand, byte by byte.
  localparam logic [MS-1:0] CIPHER = {16{32'hDF8EFB88}};

  xor_link_host #(.KEY_SIZE(KS), .MSG_SIZE(MS), .TIMEOUT(TO)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iKey(iKey), .iMessage(iMessage),
    .iSerial_out(iSerial_out), .iSerial_start(iSerial_start), .iSerial_end(iSerial_end),
    .oSerial_in(oSerial_in), .oLoad_key(oLoad_key), .oLoad_msg(oLoad_msg),
    .oBusy(oBusy), .oCiphertext(oCiphertext), .oDone(oDone), .oError(oError)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [MS-1:0] observed,
                             input logic [MS-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step;
    @(posedge iClk);
    #1;
  endtask

  // Accepts a transaction at edge 0 and checks busy/error right after it.
  task automatic applyStimulus(input logic [KS-1:0] key, input logic [MS-1:0] msg);
    iKey     = key;
    iMessage = msg;
    iStart   = 1'b1;
    step();
    iStart   = 1'b0;
    checkOutput("startBusy", MS'(oBusy), MS'(1));
    checkOutput("startErrClr", MS'(oError), MS'(0));
  endtask

  // Cycles 1..KS+MS+1; optionally pokes cipher flags and iStart mid-message.
  task automatic sendPhase(input logic [KS-1:0] key, input logic [MS-1:0] msg,
                           input bit inject);
    logic [KS-1:0] gotKey;
    logic [MS-1:0] gotMsg;
    logic [2:0]    gapVal;
    int keyHi, msgHi, early;
    gotKey = '0;
    gotMsg = '0;
    keyHi  = 0;
    msgHi  = 0;
    early  = 0;
    for (int k = 1; k <= KS; k++) begin
      step();
      if (oLoad_key && !oLoad_msg) keyHi++;
      gotKey = {gotKey[KS-2:0], oSerial_in};
    end
    step();
    gapVal = {oLoad_key, oLoad_msg, oSerial_in};
    for (int k = 1; k <= MS; k++) begin
      if (inject && k == 50) begin
        iSerial_start = 1'b1;
        iSerial_end   = 1'b1;
        iSerial_out   = 1'b1;
        iStart        = 1'b1;
        iKey          = '0;
        iMessage      = '0;
      end else if (inject && k == 51) begin
        iSerial_start = 1'b0;
        iSerial_end   = 1'b0;
        iSerial_out   = 1'b0;
        iStart        = 1'b0;
      end
      step();
      if (oLoad_msg && !oLoad_key) msgHi++;
      if (oDone || !oBusy) early++;
      gotMsg = {gotMsg[MS-2:0], oSerial_in};
    end
    checkOutput("keyStrobeCycles", MS'(keyHi), MS'(KS));
    checkOutput("keyBits", MS'(gotKey), MS'(key));
    checkOutput("gapAllLow", MS'(gapVal), MS'(0));
    checkOutput("msgStrobeCycles", MS'(msgHi), MS'(MS));
    checkOutput("msgBits", gotMsg, msg);
    checkOutput("noEarlyDone", MS'(early), MS'(0));
  endtask

  // Plays a cipher frame starting on the first WAIT_RX edge.
  task automatic receiveFrame(input string tag, input logic [MS-1:0] frame,
                              input int endBit, input int nBits, input int expDoneAt,
                              input logic expErr, output logic [MS-1:0] ctAtDone);
    int doneAt, pulses;
    logic busyAtDone, errAtDone;
    doneAt     = 0;
    pulses     = 0;
    busyAtDone = 1'b0;
    errAtDone  = 1'b0;
    ctAtDone   = '0;
    for (int i = 1; i <= nBits; i++) begin
      iSerial_out   = (i <= MS) ? frame[MS-i] : 1'b1;
      iSerial_start = (i == 1);
      iSerial_end   = (i == endBit);
      step();
      if (oDone) begin
        pulses++;
        if (doneAt == 0) begin
          doneAt     = i;
          busyAtDone = oBusy;
          errAtDone  = oError;
          ctAtDone   = oCiphertext;
        end
      end
    end
    iSerial_out   = 1'b0;
    iSerial_start = 1'b0;
    iSerial_end   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (oDone) pulses++;
    end
    checkOutput({tag, "_doneAt"}, MS'(doneAt), MS'(expDoneAt));
    checkOutput({tag, "_pulses"}, MS'(pulses), MS'(1));
    checkOutput({tag, "_errAtDone"}, MS'(errAtDone), MS'(expErr));
    checkOutput({tag, "_busyAtDone"}, MS'(busyAtDone), MS'(1));
    checkOutput({tag, "_idleAfter"}, MS'(oBusy), MS'(0));
    checkOutput({tag, "_errSticky"}, MS'(oError), MS'(expErr));
  endtask

  initial begin
    logic [MS-1:0] ct;
    int doneAt, pulses;
    logic errBefore, errAtDone;

    iRst          = 1'b1;
    iStart        = 1'b0;
    iKey          = '0;
    iMessage      = '0;
    iSerial_out   = 1'b0;
    iSerial_start = 1'b0;
    iSerial_end   = 1'b0;
    step();
    step();
    checkOutput("resetCtrl", MS'({oSerial_in, oLoad_key, oLoad_msg, oBusy, oDone, oError}), MS'(0));
    checkOutput("resetCipher", oCiphertext, '0);
    iRst = 1'b0;
    step();

    $display("[TB] framing and loopback");
    applyStimulus(KEY, MSG);
    sendPhase(KEY, MSG, 1'b0);
    receiveFrame("loop", CIPHER, MS, MS, MS, 1'b0, ct);
    checkOutput("loopCipher", ct, CIPHER);
    checkOutput("loopCipherHeld", oCiphertext, CIPHER);

    $display("[TB] reset during SEND_MSG");
    applyStimulus(KEY, MSG);
    for (int i = 0; i < 100; i++) step();
    iRst = 1'b1;
    step();
    checkOutput("midResetCtrl", MS'({oSerial_in, oLoad_key, oLoad_msg, oBusy, oDone, oError}), MS'(0));
    step();
    step();
    checkOutput("midResetCipher", oCiphertext, '0);
    iRst = 1'b0;
    step();
    applyStimulus(KEY, MSG);
    sendPhase(KEY, MSG, 1'b0);
    receiveFrame("afterReset", CIPHER, MS, MS, MS, 1'b0, ct);
    checkOutput("afterResetCipher", ct, CIPHER);

    $display("[TB] short frame");
    applyStimulus(KEY, MSG);
    sendPhase(KEY, MSG, 1'b0);
    receiveFrame("short", CIPHER, 100, 100, 100, 1'b1, ct);

    $display("[TB] overrun");
    applyStimulus(KEY, MSG);
    sendPhase(KEY, MSG, 1'b0);
    receiveFrame("overrun", CIPHER, 0, MS + 8, MS, 1'b1, ct);

    $display("[TB] timeout with stray flags during SEND_MSG");
    applyStimulus(KEY, MSG);
    sendPhase(KEY, MSG, 1'b1);
    doneAt    = 0;
    pulses    = 0;
    errBefore = 1'b0;
    errAtDone = 1'b0;
    for (int t = 1; t <= TO + 10; t++) begin
      step();
      if (t == TO - 1) errBefore = oError;
      if (oDone) begin
        pulses++;
        if (doneAt == 0) begin
          doneAt    = t;
          errAtDone = oError;
        end
      end
    end
    checkOutput("tmoDoneAt", MS'(doneAt), MS'(TO));
    checkOutput("tmoErrBefore", MS'(errBefore), MS'(0));
    checkOutput("tmoErrAtDone", MS'(errAtDone), MS'(1));
    checkOutput("tmoPulses", MS'(pulses), MS'(1));
    checkOutput("tmoIdleAfter", MS'(oBusy), MS'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
